// File: rtl/mac_accumulator_if.sv
// Handshake bundle for the MAC accumulator: a product stream in and a
// saturated dot-product result stream out, both valid/ready.
interface mac_accumulator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sat;

    // Producer of products / consumer of results (upstream + downstream side)
    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sat
    );

    // The accumulator itself
    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sat
    );
endinterface

// File: rtl/mac_accumulator.sv
// Sign-magnitude dot-product accumulator. Sums VEC_LEN sign-magnitude
// products in a two's-complement accumulator with ACC_GUARD guard bits,
// then presents the sum as a saturated sign-magnitude word and holds it
// until the downstream handshake completes.
module mac_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int VEC_LEN    = 4,
    parameter int ACC_GUARD  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mac_accumulator_if.slave  bus
);

    localparam int ACC_W = DATA_WIDTH + ACC_GUARD;
    localparam int MAG_W = DATA_WIDTH - 1;
    localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Largest representable output magnitude, widened to accumulator width.
    localparam logic [ACC_W-1:0] MAG_MAX  = ACC_W'({MAG_W{1'b1}});

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Sign-magnitude to two's complement; negative zero maps to zero.
    function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [DATA_WIDTH-1:0] sm);
        logic [ACC_W-1:0] mag;
        mag = ACC_W'(sm[MAG_W-1:0]);
        if (sm[DATA_WIDTH-1] == 1'b1) begin
            sm_to_tc = -$signed(mag);
        end else begin
            sm_to_tc = $signed(mag);
        end
    endfunction

    // Two's complement sum to saturated sign-magnitude, packed as {sat, word}.
    // A zero sum has a clear sign bit, so negative zero is never produced.
    function automatic logic [DATA_WIDTH:0] tc_to_sm_sat(input logic signed [ACC_W-1:0] sum);
        logic             neg;
        logic [ACC_W-1:0] mag;
        logic [MAG_W-1:0] mag_out;
        logic             sat;
        neg = sum[ACC_W-1];
        if (neg == 1'b1) begin
            mag = ACC_W'(-sum);
        end else begin
            mag = ACC_W'(sum);
        end
        if (mag > MAG_MAX) begin
            mag_out = {MAG_W{1'b1}};
            sat     = 1'b1;
        end else begin
            mag_out = mag[MAG_W-1:0];
            sat     = 1'b0;
        end
        tc_to_sm_sat = {sat, neg, mag_out};
    endfunction

    state_t                  state_r;
    state_t                  state_n_s;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_n_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_n_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [DATA_WIDTH:0]     result_s;
    logic                    load_s;

    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    out_sat_r;

    // Next-state, accumulator and counter update for the ACCUM/HOLD FSM
    always_comb begin
        state_n_s = state_r;
        acc_n_s   = acc_r;
        cnt_n_s   = cnt_r;
        load_s    = 1'b0;
        sum_s     = acc_r + sm_to_tc(bus.in_data);
        result_s  = tc_to_sm_sat(sum_s);
        case (state_r)
            ST_ACCUM: begin
                if (bus.in_valid == 1'b1) begin
                    if (cnt_r == CNT_LAST) begin
                        // Final beat: publish the sum including this beat and restart.
                        load_s    = 1'b1;
                        state_n_s = ST_HOLD;
                        acc_n_s   = '0;
                        cnt_n_s   = '0;
                    end else begin
                        acc_n_s = sum_s;
                        cnt_n_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    // Gap in the product stream: keep partial sum and count.
                    state_n_s = ST_ACCUM;
                end
            end
            ST_HOLD: begin
                // Input side is closed; only the result handshake matters.
                if (bus.out_ready == 1'b1) begin
                    state_n_s = ST_ACCUM;
                end else begin
                    state_n_s = ST_HOLD;
                end
            end
            default: begin
                state_n_s = ST_ACCUM;
                acc_n_s   = '0;
                cnt_n_s   = '0;
            end
        endcase
    end

    // State, accumulator and counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_ACCUM;
            acc_r   <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n_s;
            acc_r   <= acc_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Registered handshake flags decoded from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_n_s == ST_ACCUM);
            out_valid_r <= (state_n_s == ST_HOLD);
        end
    end

    // Result registers: loaded on the last beat, otherwise held stable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_data_r <= '0;
            out_sat_r  <= 1'b0;
        end else if (load_s) begin
            out_data_r <= result_s[DATA_WIDTH-1:0];
            out_sat_r  <= result_s[DATA_WIDTH];
        end else begin
            out_data_r <= out_data_r;
            out_sat_r  <= out_sat_r;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed, table-driven bench for mac_accumulator (16-bit words, 4 beats).
module tb_mac_accumulator;

    logic clk;
    logic resetn;

    mac_accumulator_if #(.DATA_WIDTH(16)) bus ();

    mac_accumulator #(
        .DATA_WIDTH(16),
        .VEC_LEN   (4),
        .ACC_GUARD (4)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] beats [4];
        logic [15:0] exp_data;
        logic        exp_sat;
        string       name;
    } vec_t;

    localparam int NVEC = 10;
    vec_t tbl [NVEC];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3,
                           input logic [15:0] ed, input logic es, input string nm);
        tbl[idx].beats[0] = b0;
        tbl[idx].beats[1] = b1;
        tbl[idx].beats[2] = b2;
        tbl[idx].beats[3] = b3;
        tbl[idx].exp_data = ed;
        tbl[idx].exp_sat  = es;
        tbl[idx].name     = nm;
    endtask

    // Feed one vector; optional random idle cycles before each beat.
    // Leaves the DUT in HOLD with the result checked.
    task automatic run_vec(input int idx, input bit gaps);
        int n;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = 16'($urandom);
                    @(posedge clk); #1;
                end
            end
            check({tbl[idx].name, ".in_ready"}, 32'(bus.in_ready), 32'd1);
            check({tbl[idx].name, ".out_valid_early"}, 32'(bus.out_valid), 32'd0);
            bus.in_valid = 1'b1;
            bus.in_data  = tbl[idx].beats[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        check({tbl[idx].name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tbl[idx].name, ".out_data"}, 32'(bus.out_data), 32'(tbl[idx].exp_data));
        check({tbl[idx].name, ".out_sat"}, 32'(bus.out_sat), 32'(tbl[idx].exp_sat));
        check({tbl[idx].name, ".in_ready_hold"}, 32'(bus.in_ready), 32'd0);
    endtask

    // Complete the result handshake and confirm return to ACCUM.
    task automatic release_out(input string nm);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({nm, ".released_valid"}, 32'(bus.out_valid), 32'd0);
        check({nm, ".released_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] held;

        set_vec(0, 16'h0005, 16'h8003, 16'h0010, 16'h0001, 16'h0013, 1'b0, "basic");
        set_vec(1, 16'h8005, 16'h8005, 16'h0002, 16'h0000, 16'h8008, 1'b0, "negative");
        set_vec(2, 16'h0004, 16'h8004, 16'h8000, 16'h0000, 16'h0000, 1'b0, "zero_sum");
        set_vec(3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, "sat_pos");
        set_vec(4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, "sat_neg");
        set_vec(5, 16'h4000, 16'h3FFF, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, "max_exact");
        set_vec(6, 16'h4000, 16'h4000, 16'h0000, 16'h8000, 16'h7FFF, 1'b1, "pos_just_over");
        set_vec(7, 16'hC000, 16'hC000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, "neg_min_sat");
        set_vec(8, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 1'b0, "neg_zeros");
        set_vec(9, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0004, 1'b0, "ones");

        resetn        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.out_data", 32'(bus.out_data), 32'd0);
        check("reset.out_sat", 32'(bus.out_sat), 32'd0);
        resetn = 1'b1;

        // Back-to-back pass over the table
        for (int v = 0; v < NVEC; v++) begin
            run_vec(v, 1'b0);
            release_out(tbl[v].name);
        end

        // Same table with random gaps between beats
        for (int v = 0; v < NVEC; v++) begin
            run_vec(v, 1'b1);
            release_out(tbl[v].name);
        end

        // Backpressure: result held, input ignored while in HOLD
        run_vec(0, 1'b0);
        held          = bus.out_data;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h1234;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp.in_ready", 32'(bus.in_ready), 32'd0);
            check("bp.out_valid", 32'(bus.out_valid), 32'd1);
            check("bp.out_data", 32'(bus.out_data), 32'(held));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("bp.release_ready", 32'(bus.in_ready), 32'd1);
        run_vec(9, 1'b0);
        release_out("bp_next");

        // Reset mid-vector: partial sum discarded
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0005;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        resetn       = 1'b0;
        #2;
        check("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        run_vec(9, 1'b0);
        release_out("rst_mid");

        // Reset while holding a saturated result
        run_vec(3, 1'b0);
        resetn = 1'b0;
        #2;
        check("rst_hold.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_hold.out_data", 32'(bus.out_data), 32'd0);
        check("rst_hold.out_sat", 32'(bus.out_sat), 32'd0);
        check("rst_hold.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b1;
        run_vec(9, 1'b0);
        release_out("rst_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
